// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, sequencer state and
// instruction-class encodings, and the datapath select encodings.
package core_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_HALT    = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_SYSTEM, CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    seq_state_t state;
    op_class_t  cls;
    logic [2:0] funct3;
  } seq_dbg_t;

  // ALU-using classes are only legal when operand control agrees (alu_en).
  function automatic op_class_t decode_class(input logic [6:0] opc,
                                             input logic       alu_en);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    case (opc)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: cls = alu_en ? CLS_ALU   : CLS_ILLEGAL;
      OPC_LOAD:   cls = alu_en ? CLS_LOAD  : CLS_ILLEGAL;
      OPC_STORE:  cls = alu_en ? CLS_STORE : CLS_ILLEGAL;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction/data memory handshake between the sequencer and the memories.
// Handshake: a req stays high until ack is sampled high on a rising clock
// edge; ack is meaningful only while req is high; the transfer completes on
// that edge and the requester drops req on the following cycle. dmem_we is
// valid only while dmem_req is high.
interface exec_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/seq_timeout_ctr.sv
// Bus-wait down-counter shared by FETCH and MEM: reloaded while no request is
// outstanding, decremented on each unacknowledged request cycle.
module seq_timeout_ctr #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= 8'(MEM_TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Flags the MEM_TIMEOUT-th waiting cycle itself, so an ack arriving in
  // that same cycle can still take priority in the sequencer.
  assign expired = en && (cnt == 8'd1);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with
// retired-instruction counter and sticky trap on illegal opcode/bus timeout.
module exec_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  alu_en,
  input  logic                  br_taken,
  exec_sequencer_if.master      mem,
  output logic                  ir_load,
  output logic                  alu_latch,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output seq_dbg_t              dbg
);

  seq_state_t       state;
  op_class_t        cls_q;
  op_class_t        dec_cls;
  logic [2:0]       f3_q;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             alu_latch_q;
  logic             pc_we_q;
  logic [1:0]       pc_sel_q;
  logic             rf_we_q;
  logic [1:0]       wb_sel_q;
  logic             retire_q;
  logic [CNT_W-1:0] instret_q;
  logic             trap_q;
  logic [1:0]       cause_q;

  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_expired;

  logic             wb_rf_we;
  logic [1:0]       wb_sel_nxt;
  logic [1:0]       pc_sel_nxt;

  assign tmo_clr = !(imem_req_q || dmem_req_q);
  assign tmo_en  = (imem_req_q && !mem.imem_ack) || (dmem_req_q && !mem.dmem_ack);

  seq_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign dec_cls = decode_class(opcode, alu_en);

  // Writeback controls for the instruction in flight; br_taken only matters
  // on the EXEC->WB transition of a branch.
  always_comb begin
    wb_rf_we   = 1'b1;
    wb_sel_nxt = WB_SEL_ALU;
    pc_sel_nxt = PC_SEL_PLUS4;
    case (cls_q)
      CLS_LOAD:   wb_sel_nxt = WB_SEL_LOAD;
      CLS_STORE:  wb_rf_we = 1'b0;
      CLS_BRANCH: begin
        wb_rf_we = 1'b0;
        if (br_taken) pc_sel_nxt = PC_SEL_TARGET;
      end
      CLS_JAL: begin
        wb_sel_nxt = WB_SEL_LINK;
        pc_sel_nxt = PC_SEL_TARGET;
      end
      CLS_JALR: begin
        wb_sel_nxt = WB_SEL_LINK;
        pc_sel_nxt = PC_SEL_JALR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      cls_q       <= CLS_ALU;
      f3_q        <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      alu_latch_q <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= PC_SEL_PLUS4;
      rf_we_q     <= 1'b0;
      wb_sel_q    <= WB_SEL_ALU;
      retire_q    <= 1'b0;
      instret_q   <= '0;
      trap_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      alu_latch_q <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      retire_q    <= 1'b0;
      pc_sel_q    <= PC_SEL_PLUS4;
      wb_sel_q    <= WB_SEL_ALU;
      if (retire_q) instret_q <= instret_q + CNT_W'(1);

      case (state)
        S_FETCH: begin
          // After reset the request is raised one cycle late, so a reset
          // always leaves both requests low on its first edge.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (mem.imem_ack) begin
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end else if (tmo_expired) begin
            imem_req_q <= 1'b0;
            state      <= S_TRAP;
            trap_q     <= 1'b1;
            cause_q    <= CAUSE_BUS;
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          f3_q  <= funct3;
          if (dec_cls == CLS_SYSTEM) begin
            state   <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_HALT;
          end else if (dec_cls == CLS_ILLEGAL) begin
            state   <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state       <= S_EXEC;
            alu_latch_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
            state      <= S_MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == CLS_STORE);
          end else begin
            state    <= S_WB;
            pc_we_q  <= 1'b1;
            retire_q <= 1'b1;
            rf_we_q  <= wb_rf_we;
            wb_sel_q <= wb_sel_nxt;
            pc_sel_q <= pc_sel_nxt;
          end
        end
        S_MEM: begin
          if (mem.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state      <= S_WB;
            pc_we_q    <= 1'b1;
            retire_q   <= 1'b1;
            rf_we_q    <= wb_rf_we;
            wb_sel_q   <= wb_sel_nxt;
            pc_sel_q   <= pc_sel_nxt;
          end else if (tmo_expired) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state      <= S_TRAP;
            trap_q     <= 1'b1;
            cause_q    <= CAUSE_BUS;
          end
        end
        S_WB: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_TRAP: ;
        default: state <= S_TRAP;
      endcase
    end
  end

  // IR capture must coincide with the cycle the fetch data is valid, so this
  // one strobe is decoded from the live ack rather than registered.
  assign ir_load      = (state == S_FETCH) && imem_req_q && mem.imem_ack;
  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign alu_latch    = alu_latch_q;
  assign pc_we        = pc_we_q;
  assign pc_sel       = pc_sel_q;
  assign rf_we        = rf_we_q;
  assign wb_sel       = wb_sel_q;
  assign retire       = retire_q;
  assign instret      = instret_q;
  assign trap         = trap_q;
  assign trap_cause   = cause_q;
  assign dbg          = '{state: state, cls: cls_q, funct3: f3_q};

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus randomized
// instruction streams checked against a table-driven timing/outcome model.
module tb_exec_sequencer;
  import core_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int NEVER = 99;

  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          alu_en = 1'b0;
  logic          br_taken = 1'b0;
  logic          ir_load, alu_latch, pc_we, rf_we, retire, trap;
  logic [1:0]    pc_sel, wb_sel, trap_cause;
  logic [CW-1:0] instret;
  seq_dbg_t      dbg;

  exec_sequencer_if mem_if ();

  exec_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_en     (alu_en),
    .br_taken   (br_taken),
    .mem        (mem_if),
    .ir_load    (ir_load),
    .alu_latch  (alu_latch),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .retire     (retire),
    .instret    (instret),
    .trap       (trap),
    .trap_cause (trap_cause),
    .dbg        (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [47:0] exp_q[$];

  // observations of one instruction, cycle 1 = first cycle with imem_req high
  int          o_ir_cyc, o_alu_cyc, o_ret_cyc, o_trap_cyc, o_dreq_n, o_dwe_n, o_stray;
  logic        o_rf_we, o_pc_we, o_req_at_trap;
  logic [1:0]  o_wb_sel, o_pc_sel, o_cause;
  logic [CW-1:0] o_instret0;

  task automatic do_reset();
    rst_n = 1'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one instruction: memories ack after iwait/dwait unacked request
  // cycles; br_taken is the intended value only during the ALU-latch cycle.
  task automatic run_instr(input logic [6:0] opc, input logic aen, input logic br,
                           input int iwait, input int dwait);
    int  c, ireq, dreq;
    bit  started, done;
    o_ir_cyc = -1; o_alu_cyc = -1; o_ret_cyc = -1; o_trap_cyc = -1;
    o_dreq_n = 0; o_dwe_n = 0; o_stray = 0;
    o_rf_we = 1'b0; o_pc_we = 1'b0; o_req_at_trap = 1'b0;
    o_wb_sel = 2'b00; o_pc_sel = 2'b00; o_cause = 2'b00; o_instret0 = '0;
    opcode = opc; funct3 = 3'($urandom_range(0, 7)); alu_en = aen;
    c = 0; ireq = 0; dreq = 0; started = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (mem_if.imem_req) started = 1;
      if (started) c++;
      br_taken = alu_latch ? br : ~br;
      mem_if.imem_ack = mem_if.imem_req && (ireq == iwait);
      if (mem_if.imem_req) ireq++;
      mem_if.dmem_ack = mem_if.dmem_req && (dreq == dwait);
      if (mem_if.dmem_req) begin
        dreq++;
        o_dreq_n++;
        if (mem_if.dmem_we) o_dwe_n++;
      end
      #1;
      if (c == 1) o_instret0 = instret;
      if (ir_load) o_ir_cyc = c;
      if (alu_latch) o_alu_cyc = c;
      if (retire) begin
        o_ret_cyc = c; o_rf_we = rf_we; o_pc_we = pc_we;
        o_wb_sel = wb_sel; o_pc_sel = pc_sel; done = 1;
      end else if (pc_we || rf_we) begin
        o_stray++;
      end
      if (trap) begin
        o_trap_cyc = c; o_cause = trap_cause;
        o_req_at_trap = mem_if.imem_req | mem_if.dmem_req; done = 1;
      end
    end
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
  endtask

  // Reference model: outcome and cycle positions from the instruction rules.
  function automatic logic [47:0] model_word(input logic [6:0] opc, input logic aen,
                                             input logic br, input int iwait, input int dwait);
    logic is_alu_user, is_ctrl, is_mem, is_store, m_trap, m_rf;
    logic [1:0] m_cause, m_wb, m_pc;
    int ir_c, alu_c, ret_c, trap_c, dreq_n;
    is_alu_user = opc inside {T_OPIMM, T_OP, T_LOAD, T_STORE, T_LUI, T_AUIPC};
    is_ctrl     = opc inside {T_BRANCH, T_JAL, T_JALR};
    is_mem      = opc inside {T_LOAD, T_STORE};
    is_store    = (opc == T_STORE);
    m_trap = 1'b0; m_cause = 2'b00; m_rf = 1'b0; m_wb = 2'b00; m_pc = 2'b00;
    ir_c = -1; alu_c = -1; ret_c = -1; trap_c = -1; dreq_n = 0;
    if (iwait >= TMO) begin
      m_trap = 1'b1; m_cause = 2'b10; trap_c = TMO + 1;
    end else if (opc == T_SYSTEM || !(is_ctrl || (is_alu_user && aen))) begin
      ir_c = iwait + 1; m_trap = 1'b1; trap_c = iwait + 3;
      m_cause = (opc == T_SYSTEM) ? 2'b11 : 2'b01;
    end else begin
      ir_c = iwait + 1; alu_c = iwait + 3;
      if (is_mem && dwait >= TMO) begin
        dreq_n = TMO; m_trap = 1'b1; m_cause = 2'b10; trap_c = iwait + 3 + TMO + 1;
      end else begin
        dreq_n = is_mem ? dwait + 1 : 0;
        ret_c  = is_mem ? iwait + dwait + 5 : iwait + 4;
        m_rf   = !(is_store || opc == T_BRANCH);
        m_wb   = (opc == T_LOAD) ? 2'b01 : (opc == T_JAL || opc == T_JALR) ? 2'b10 : 2'b00;
        m_pc   = (opc == T_JAL || (opc == T_BRANCH && br)) ? 2'b01 : (opc == T_JALR) ? 2'b10 : 2'b00;
      end
    end
    return {m_trap, m_cause, m_rf, m_wb, m_pc, 8'(ir_c), 8'(alu_c), 8'(ret_c), 8'(trap_c), 8'(dreq_n)};
  endfunction

  function automatic logic [47:0] obs_word();
    return {o_trap_cyc >= 0, o_cause, o_rf_we, o_wb_sel, o_pc_sel, 8'(o_ir_cyc),
            8'(o_alu_cyc), 8'(o_ret_cyc), 8'(o_trap_cyc), 8'(o_dreq_n)};
  endfunction

  task automatic test_reset();
    int k;
    rst_n = 1'b0; opcode = T_LOAD; alu_en = 1'b1;
    mem_if.imem_ack = 1'b0; mem_if.dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_load, alu_latch, pc_we, pc_sel,
         rf_we, wb_sel, retire, instret, trap, trap_cause} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    n_cmp++;
    if (dbg.state !== S_FETCH) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg.state, S_FETCH);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (mem_if.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_fetch_start: imem_req got %b required 1", mem_if.imem_req);
    end
    // reset in the middle of a load that never completes
    mem_if.imem_ack = 1'b1;
    @(negedge clk); mem_if.imem_ack = 1'b0;
    k = 0;
    while (!mem_if.dmem_req && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (mem_if.dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL midop_reach_mem: dmem_req got %b required 1", mem_if.dmem_req);
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_if.imem_req, mem_if.dmem_req, dbg.state} !== {1'b0, 1'b0, S_FETCH}) begin
      n_fail++; $display("FAIL midop_reset: reqs %b%b state %0d required 00 state %0d",
                         mem_if.imem_req, mem_if.dmem_req, dbg.state, S_FETCH);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_if.imem_req, mem_if.dmem_req} !== 2'b10) begin
      n_fail++; $display("FAIL midop_no_retry: reqs got %b%b required 10", mem_if.imem_req, mem_if.dmem_req);
    end
  endtask

  task automatic test_addi();
    do_reset();
    run_instr(T_OPIMM, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if ({o_ir_cyc, o_alu_cyc, o_ret_cyc} != {32'sd1, 32'sd3, 32'sd4}) begin
      n_fail++; $display("FAIL addi_timing: ir/alu/ret got %0d/%0d/%0d required 1/3/4", o_ir_cyc, o_alu_cyc, o_ret_cyc);
    end
    n_cmp++;
    if ({o_rf_we, o_pc_we, o_wb_sel, o_pc_sel} !== 6'b11_00_00 || o_stray != 0) begin
      n_fail++; $display("FAIL addi_wb: rf/pc_we/wb/pc got %b/%b/%b/%b stray %0d required 1/1/00/00 stray 0",
                         o_rf_we, o_pc_we, o_wb_sel, o_pc_sel, o_stray);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (instret !== CW'(1)) begin
      n_fail++; $display("FAIL addi_instret: got %0d required 1", instret);
    end
  endtask

  task automatic test_load_store();
    do_reset();
    run_instr(T_LOAD, 1'b1, 1'b0, 0, 3);
    n_cmp++;
    if (o_dreq_n != 4 || o_dwe_n != 0 || o_ret_cyc != 8) begin
      n_fail++; $display("FAIL lw_mem: dreq %0d we %0d ret %0d required 4 0 8", o_dreq_n, o_dwe_n, o_ret_cyc);
    end
    n_cmp++;
    if ({o_rf_we, o_wb_sel, o_pc_sel} !== 5'b1_01_00) begin
      n_fail++; $display("FAIL lw_wb: rf/wb/pc got %b/%b/%b required 1/01/00", o_rf_we, o_wb_sel, o_pc_sel);
    end
    run_instr(T_STORE, 1'b1, 1'b0, 0, 3);
    n_cmp++;
    if (o_dreq_n != 4 || o_dwe_n != 4 || o_ret_cyc != 8) begin
      n_fail++; $display("FAIL sw_mem: dreq %0d we %0d ret %0d required 4 4 8", o_dreq_n, o_dwe_n, o_ret_cyc);
    end
    n_cmp++;
    if (o_rf_we !== 1'b0 || o_instret0 !== CW'(1)) begin
      n_fail++; $display("FAIL sw_wb: rf_we %b instret %0d required 0 1", o_rf_we, o_instret0);
    end
  endtask

  task automatic test_branch_jump();
    logic [6:0] opcs [4];
    logic       brs  [4];
    logic [4:0] exp  [4];
    opcs = '{T_BRANCH, T_BRANCH, T_JALR, T_JAL};
    brs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp  = '{5'b0_00_01, 5'b0_00_00, 5'b1_10_10, 5'b1_10_01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(opcs[i], $urandom_range(0, 1) == 1, brs[i], $urandom_range(0, 3), 0);
      n_cmp++;
      if ({o_rf_we, o_wb_sel, o_pc_sel} !== exp[i] || o_ret_cyc < 0) begin
        n_fail++; $display("FAIL ctrl_flow_%0d: rf/wb/pc got %b/%b/%b ret %0d required %b", i,
                           o_rf_we, o_wb_sel, o_pc_sel, o_ret_cyc, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int bad;
    do_reset();
    run_instr(T_BAD, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (o_trap_cyc != 3 || o_cause !== 2'b01 || o_ret_cyc != -1 || o_req_at_trap !== 1'b0) begin
      n_fail++; $display("FAIL illegal_trap: cyc %0d cause %b ret %0d req %b required 3 01 -1 0",
                         o_trap_cyc, o_cause, o_ret_cyc, o_req_at_trap);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mem_if.imem_ack = $urandom_range(0, 1) == 1;
      br_taken = $urandom_range(0, 1) == 1;
      #1;
      if (!trap || trap_cause !== 2'b01 || retire || pc_we || rf_we || alu_latch || ir_load ||
          mem_if.imem_req || mem_if.dmem_req || instret !== '0) bad++;
    end
    mem_if.imem_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL trap_sticky: %0d bad cycles required 0", bad);
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if ({trap, instret, dbg.state} !== {1'b0, CW'(0), S_FETCH}) begin
      n_fail++; $display("FAIL trap_reset_exit: trap %b instret %0d state %0d required 0 0 %0d",
                         trap, instret, dbg.state, S_FETCH);
    end
    do_reset();
    run_instr(T_OP, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (o_trap_cyc != 3 || o_cause !== 2'b01) begin
      n_fail++; $display("FAIL alu_en_mismatch: cyc %0d cause %b required 3 01", o_trap_cyc, o_cause);
    end
    do_reset();
    run_instr(T_LUI, 1'b1, 1'b0, 0, 0);
    run_instr(T_SYSTEM, 1'b1, 1'b0, 1, 0);
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (o_trap_cyc != 4 || o_cause !== 2'b11 || instret !== CW'(1)) begin
      n_fail++; $display("FAIL system_halt: cyc %0d cause %b instret %0d required 4 11 1",
                         o_trap_cyc, o_cause, instret);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(T_OPIMM, 1'b1, 1'b0, NEVER, 0);
    n_cmp++;
    if (o_trap_cyc != TMO + 1 || o_cause !== 2'b10 || o_ir_cyc != -1 || o_req_at_trap !== 1'b0) begin
      n_fail++; $display("FAIL fetch_timeout: cyc %0d cause %b ir %0d req %b required %0d 10 -1 0",
                         o_trap_cyc, o_cause, o_ir_cyc, o_req_at_trap, TMO + 1);
    end
    do_reset();
    run_instr(T_OPIMM, 1'b1, 1'b0, TMO - 1, 0);
    n_cmp++;
    if (o_trap_cyc != -1 || o_ir_cyc != TMO || o_ret_cyc != TMO + 3) begin
      n_fail++; $display("FAIL fetch_ack_at_expiry: trap %0d ir %0d ret %0d required -1 %0d %0d",
                         o_trap_cyc, o_ir_cyc, o_ret_cyc, TMO, TMO + 3);
    end
    do_reset();
    run_instr(T_LOAD, 1'b1, 1'b0, 0, NEVER);
    n_cmp++;
    if (o_trap_cyc != TMO + 4 || o_cause !== 2'b10 || o_dreq_n != TMO || o_req_at_trap !== 1'b0) begin
      n_fail++; $display("FAIL mem_timeout: cyc %0d cause %b dreq %0d req %b required %0d 10 %0d 0",
                         o_trap_cyc, o_cause, o_dreq_n, o_req_at_trap, TMO + 4, TMO);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(T_OPIMM, 1'b1, 1'b0, $urandom_range(0, 3), 0);
    n_cmp++;
    if (o_instret0 !== CW'(15)) begin
      n_fail++; $display("FAIL wrap_before: instret got %0d required 15", o_instret0);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (instret !== CW'(0)) begin
      n_fail++; $display("FAIL wrap_after: instret got %0d required 0", instret);
    end
  endtask

  task automatic test_random();
    logic [6:0]  pool [12];
    logic [6:0]  opc;
    logic        aen, br;
    int          iw, dw, m_cnt;
    logic [47:0] exp_w, got_w;
    pool = '{T_OPIMM, T_OP, T_LOAD, T_STORE, T_LUI, T_AUIPC, T_BRANCH, T_JAL, T_JALR,
             T_SYSTEM, T_BAD, 7'b0001111};
    do_reset();
    m_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      opc = pool[$urandom_range(0, 11)];
      aen = $urandom_range(0, 7) != 0;
      br  = $urandom_range(0, 1) == 1;
      iw  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
      dw  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 3);
      exp_q.push_back(model_word(opc, aen, br, iw, dw));
      run_instr(opc, aen, br, iw, dw);
      exp_w = exp_q.pop_front();
      got_w = obs_word();
      n_cmp++;
      if (got_w !== exp_w) begin
        n_fail++; $display("FAIL rand_%0d op %b: got %h required %h", i, opc, got_w, exp_w);
      end
      n_cmp++;
      if (o_instret0 !== CW'(m_cnt) || o_stray != 0 ||
          o_dwe_n != ((opc == T_STORE) ? o_dreq_n : 0)) begin
        n_fail++; $display("FAIL rand_%0d_side: instret %0d stray %0d dwe %0d required %0d 0 %0d", i,
                           o_instret0, o_stray, o_dwe_n, m_cnt, (opc == T_STORE) ? o_dreq_n : 0);
      end
      if (exp_w[47]) begin
        do_reset();
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  endtask

  initial begin
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    test_reset();
    test_addi();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, ALU execute, data-memory access and writeback around the shared single ALU and its operand-select logic.
- Drives instruction-register load, PC update, register-file write and memory handshakes.
- Owns the retired-instruction counter and the bus-timeout / illegal-instruction trap.
- Sits between the instruction/data memory ports and the ALU operand-control, register-file and PC blocks.

Parameters:
- MEM_TIMEOUT, 255: max cycles a fetch or data request may wait for ACK before a bus-error trap; range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- OPCODE  in  7  instruction[6:0] from the instruction register.
- FUNCT3  in  3  instruction[14:12].
- ALU_EN  in  1  from ALU operand control; high for ALU-using opcodes.
- BR_TAKEN  in  1  branch comparator result, valid in EXEC.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ACK  in  1  fetch data valid; completes the request.
- DMEM_REQ  out  1  data access request.
- DMEM_WE  out  1  1 = store, 0 = load; valid while DMEM_REQ.
- DMEM_ACK  in  1  data access complete.
- IR_LOAD  out  1  capture instruction into IR.
- ALU_LATCH  out  1  capture ALU result into ALU_OUT register.
- PC_WE  out  1  update PC.
- PC_SEL  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 {ALU_OUT[31:1],0} (JALR).
- RF_WE  out  1  register-file write enable.
- WB_SEL  out  2  00 ALU_OUT, 01 load data, 10 PC+4.
- RETIRE  out  1  one-cycle pulse per committed instruction.
- INSTRET  out  CNT_W  retired-instruction count.
- TRAP  out  1  sticky fault flag.
- TRAP_CAUSE  out  2  01 illegal opcode, 10 bus timeout, 11 ECALL/EBREAK halt.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → FETCH.
- Reset values: all outputs 0; INSTRET = 0; timeout counter = 0.
- Reset mid-operation: next edge is FETCH with REQs low. An abandoned memory request is not retried.
- FETCH:
  - IMEM_REQ = 1, held until IMEM_ACK.
  - On ACK: IR_LOAD = 1 for that cycle → DECODE.
- DECODE (1 cycle), by opcode class:
  - OP-IMM, OP, LOAD, STORE, LUI, AUIPC, BRANCH, JAL, JALR → EXEC.
  - 1110011 (SYSTEM) → TRAP with cause 11.
  - Any other opcode → TRAP with cause 01.
  - OP-IMM/OP/LOAD/STORE/LUI/AUIPC with ALU_EN = 0 is a consistency error → TRAP cause 01.
- EXEC (1 cycle): ALU_LATCH = 1.
  - LOAD/STORE → MEM.
  - All other classes → WB.
- MEM:
  - DMEM_REQ = 1; DMEM_WE = 1 for STORE, 0 for LOAD; held until DMEM_ACK.
  - On ACK → WB.
- WB (1 cycle): PC_WE = 1; RETIRE = 1; INSTRET += 1 (wraps at all-ones → 0); → FETCH.
  - RF_WE = 1 except for STORE and BRANCH.
  - WB_SEL: 01 for LOAD, 10 for JAL/JALR, else 00.
  - PC_SEL: 01 for JAL, or for BRANCH with BR_TAKEN registered in EXEC; 10 for JALR; else 00.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle a REQ is high without ACK.
  - Reaching MEM_TIMEOUT → TRAP cause 10, REQ dropped next cycle.
  - ACK in the same cycle as expiry: ACK wins, no trap.
- TRAP:
  - TRAP = 1, TRAP_CAUSE held, all enables and REQs 0. Exit only by reset.
  - No RETIRE; PC and INSTRET frozen.
- Minimum latency with zero-wait memory (ACK in the first REQ cycle):
  - ALU/branch/jump instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
- BR_TAKEN is sampled only in EXEC; it is ignored in other states.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM);
  - state enum seq_state_t;
  - PC_SEL / WB_SEL / TRAP_CAUSE encodings.
- One sub-module, seq_timeout_ctr: the MEM_TIMEOUT down-counter with clear/enable and expiry flag, reused by both the FETCH and MEM states.

Test Plan:
- ADDI (OPCODE 0010011, ALU_EN 1), IMEM_ACK in first cycle → IR_LOAD at cycle 1, ALU_LATCH cycle 3, RF_WE+PC_WE+RETIRE cycle 4, WB_SEL 00, PC_SEL 00, INSTRET 0→1.
- LW with DMEM_ACK delayed 3 cycles → DMEM_REQ high 4 cycles, DMEM_WE 0, WB RF_WE 1, WB_SEL 01; SW same delay → RF_WE 0 in WB.
- BEQ with BR_TAKEN 1 then 0 → PC_SEL 01 / 00, RF_WE 0; JALR → PC_SEL 10, WB_SEL 10, RF_WE 1.
- OPCODE 1111111 → TRAP=1, cause 01 one cycle after DECODE, no RETIRE; stays trapped for 100 cycles; RST_N low one edge → FETCH, TRAP 0, INSTRET 0.
- MEM_TIMEOUT=4, IMEM_ACK never → trap cause 10 after 4 REQ cycles; repeat with ACK on the 4th cycle → no trap, DECODE entered.
- Force INSTRET to all-ones via 2^CNT_W-1 retires (CNT_W=4 build, 15 retires) → next retire wraps to 0.
